// File: rtl/max7219_spi_rx_if.sv
// Serial pin and decoded word bundle for the MAX7219 receive decoder.
// slave = decoder side (pins in, words out); master = pin driver / word consumer.
interface max7219_spi_rx_if #(
    parameter int IDX_W = 3
);
    logic             max7219_clk;
    logic             max7219_din;
    logic             max7219_load;
    logic             word_valid;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       word_addr;
    logic [7:0]       word_data;
    logic             len_err;
    logic             overrun;
    logic             busy;

    modport slave (
        input  max7219_clk, max7219_din, max7219_load,
        output word_valid, word_idx, word_addr, word_data, len_err, overrun, busy
    );

    modport master (
        output max7219_clk, max7219_din, max7219_load,
        input  word_valid, word_idx, word_addr, word_data, len_err, overrun, busy
    );
endinterface

// File: rtl/max7219_spi_rx.sv
// Decodes a MAX7219 daisy-chain frame back into per-matrix {addr,data} words.
// Optional digit register mirror enabled by MAX7219_RX_REGFILE_EN.
//   state | meaning
//   IDLE  | waiting for a load rising edge
//   EMIT  | streaming latched words idx 0..N-1, one per cycle
module max7219_spi_rx #(
    parameter  int G_NB_MATRIX   = 8,
    parameter  int G_SYNC_STAGES = 2,
    localparam int IDX_W         = (G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    max7219_spi_rx_if.slave         bus,
    input  logic [IDX_W-1:0]        i_rd_matrix,
    input  logic [2:0]              i_rd_digit,
    output logic [7:0]              o_rd_data
);
    localparam int FRAME_W = 16 * G_NB_MATRIX;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(G_NB_MATRIX - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    logic [G_SYNC_STAGES-1:0] clk_sync, din_sync, load_sync;
    logic                     clk_d, load_d;
    logic                     clk_rise, load_rise, load_lvl, din_s;

    state_t               state;
    logic [FRAME_W-1:0]   sreg, ebuf;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     emit_idx;
    logic [11:0]          cur_word;

    logic             word_valid, len_err, overrun, busy;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       word_addr;
    logic [7:0]       word_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '0;
            din_sync  <= '0;
            load_sync <= '0;
            clk_d     <= 1'b0;
            load_d    <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[G_SYNC_STAGES-2:0], bus.max7219_clk};
            din_sync  <= {din_sync[G_SYNC_STAGES-2:0], bus.max7219_din};
            load_sync <= {load_sync[G_SYNC_STAGES-2:0], bus.max7219_load};
            clk_d     <= clk_sync[G_SYNC_STAGES-1];
            load_d    <= load_sync[G_SYNC_STAGES-1];
        end
    end

    assign clk_rise  = clk_sync[G_SYNC_STAGES-1] & ~clk_d;
    assign load_rise = load_sync[G_SYNC_STAGES-1] & ~load_d;
    assign load_lvl  = load_sync[G_SYNC_STAGES-1];
    assign din_s     = din_sync[G_SYNC_STAGES-1];

    assign cur_word = ebuf[16*int'(emit_idx) +: 12];

    // A load edge wins over everything else in its cycle, including a coincident clk edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            ebuf       <= '0;
            bit_cnt    <= '0;
            emit_idx   <= '0;
            word_valid <= 1'b0;
            word_idx   <= '0;
            word_addr  <= '0;
            word_data  <= '0;
            len_err    <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            len_err    <= 1'b0;
            overrun    <= 1'b0;
            if (load_rise) begin
                ebuf     <= sreg;
                sreg     <= '0;
                bit_cnt  <= '0;
                len_err  <= (bit_cnt != CNT_FULL);
                overrun  <= (state == EMIT);
                emit_idx <= '0;
                state    <= EMIT;
                busy     <= 1'b1;
            end else begin
                if (clk_rise && !load_lvl) begin
                    sreg <= {sreg[FRAME_W-2:0], din_s};
                    if (bit_cnt != CNT_SAT)
                        bit_cnt <= bit_cnt + 1'b1;
                end
                case (state)
                    IDLE: busy <= 1'b0;
                    EMIT: begin
                        busy       <= 1'b1;
                        word_valid <= 1'b1;
                        word_idx   <= emit_idx;
                        word_addr  <= cur_word[11:8];
                        word_data  <= cur_word[7:0];
                        if (emit_idx == LAST_IDX)
                            state <= IDLE;
                        else
                            emit_idx <= emit_idx + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.word_valid = word_valid;
    assign bus.word_idx   = word_idx;
    assign bus.word_addr  = word_addr;
    assign bus.word_data  = word_data;
    assign bus.len_err    = len_err;
    assign bus.overrun    = overrun;
    assign bus.busy       = busy;

`ifdef MAX7219_RX_REGFILE_EN
    logic [7:0] regfile [G_NB_MATRIX][8];
    logic       wr_en;
    logic [2:0] wr_digit;

    // Digit registers live at addr 1..8; 3-bit wrap maps addr 8 onto digit 7.
    assign wr_en    = (state == EMIT) && !load_rise &&
                      (cur_word[11:8] >= 4'd1) && (cur_word[11:8] <= 4'd8);
    assign wr_digit = cur_word[10:8] - 3'd1;

    always_ff @(posedge clk) begin
        if (wr_en)
            regfile[emit_idx][wr_digit] <= cur_word[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            o_rd_data <= '0;
        else if (int'(i_rd_matrix) < G_NB_MATRIX)
            o_rd_data <= regfile[i_rd_matrix][i_rd_digit];
        else
            o_rd_data <= '0;
    end
`else
    wire unused_rd = ^{i_rd_matrix, i_rd_digit};
    assign o_rd_data = '0;
`endif

endmodule

// File: tb/tb_max7219_spi_rx.sv
// Scoreboard bench for max7219_spi_rx: stimulus pushes expected words, a monitor pops and compares.
module tb_max7219_spi_rx;
    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rd_matrix = '0;
    logic [2:0] rd_digit  = '0;
    logic [7:0] rd_data;

    always #5 clk = ~clk;

    max7219_spi_rx_if #(.IDX_W(3)) bus ();

    max7219_spi_rx #(.G_NB_MATRIX(8), .G_SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .i_rd_matrix (rd_matrix),
        .i_rd_digit  (rd_digit),
        .o_rd_data   (rd_data)
    );

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int n_checks = 0, n_fail = 0;
    int strobe_cnt = 0, len_err_cnt = 0, overrun_cnt = 0;
    int cyc = 0, lat_start = -1, lat_meas = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.word_valid) begin
            strobe_cnt++;
            if (lat_start >= 0 && lat_meas < 0) lat_meas = cyc - lat_start;
            if (q.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                e = q.pop_front();
                check("word_idx",  int'(bus.word_idx),  int'(e.idx));
                check("word_addr", int'(bus.word_addr), int'(e.addr));
                check("word_data", int'(bus.word_data), int'(e.data));
            end
        end
        if (bus.len_err) len_err_cnt++;
        if (bus.overrun) overrun_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input bit b);
        bus.max7219_din = b;
        bus.max7219_clk = 1'b0;
        idle(HP);
        bus.max7219_clk = 1'b1;
        idle(HP);
        bus.max7219_clk = 1'b0;
    endtask

    task automatic shift_frame(input logic [127:0] f);
        for (int i = 127; i >= 0; i--) shift_bit(f[i]);
    endtask

    task automatic pulse_load(input bit meas);
        idle(HP);
        bus.max7219_load = 1'b1;
        if (meas) lat_start = cyc;
        idle(HP);
        bus.max7219_load = 1'b0;
        idle(HP);
    endtask

    task automatic push(input int idx, input int addr, input int data);
        exp_t e;
        e.idx  = 3'(idx);
        e.addr = 4'(addr);
        e.data = 8'(data);
        q.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        idle(12);
    endtask

    task automatic clear_counts();
        strobe_cnt = 0; len_err_cnt = 0; overrun_cnt = 0;
    endtask

    // m7..m0 = 0x0108 .. 0x0801 -> idx k carries addr 8-k, data k+1
    task automatic push_frame1();
        push(0, 8, 8'h01); push(1, 7, 8'h02); push(2, 6, 8'h03); push(3, 5, 8'h04);
        push(4, 4, 8'h05); push(5, 3, 8'h06); push(6, 2, 8'h07); push(7, 1, 8'h08);
    endtask

    localparam logic [127:0] FRAME1 = 128'h0108_0207_0306_0405_0504_0603_0702_0801;
    localparam logic [127:0] FRAME4 = 128'hF8A7_F7A6_F6A5_F5A4_F4A3_F3A2_F2A1_F1A0;

    initial begin
        bus.max7219_clk  = 1'b0;
        bus.max7219_din  = 1'b0;
        bus.max7219_load = 1'b0;
        rst = 1'b1;
        idle(5);
        check("rst_word_valid", int'(bus.word_valid), 0);
        check("rst_busy",       int'(bus.busy),       0);
        check("rst_len_err",    int'(bus.len_err),    0);
        check("rst_overrun",    int'(bus.overrun),    0);
        check("rst_rd_data",    int'(rd_data),        0);
        rst = 1'b0;
        idle(5);

        // 1: full frame, latency from load pin to first strobe
        clear_counts();
        shift_frame(FRAME1);
        push_frame1();
        pulse_load(1'b1);
        drain();
        check("t1_len_err", len_err_cnt, 0);
        check("t1_strobes", strobe_cnt, 8);
        check("t1_latency", lat_meas, 4);
        check("t1_busy_after", int'(bus.busy), 0);
        lat_start = -1;

        // 2: single 16-bit word
        clear_counts();
        for (int i = 15; i >= 0; i--) shift_bit(16'h0A05 >> i);
        push(0, 4'hA, 8'h05);
        for (int k = 1; k < 8; k++) push(k, 0, 0);
        pulse_load(1'b0);
        drain();
        check("t2_len_err", len_err_cnt, 1);
        check("t2_strobes", strobe_cnt, 8);

        // 3: second load lands after 5 strobes; sreg is empty so the restart carries zeros
        clear_counts();
        shift_frame(FRAME1);
        push(0, 8, 8'h01); push(1, 7, 8'h02); push(2, 6, 8'h03); push(3, 5, 8'h04);
        push(4, 4, 8'h05);
        for (int k = 0; k < 8; k++) push(k, 0, 0);
        idle(HP);
        bus.max7219_load = 1'b1;
        idle(3);
        bus.max7219_load = 1'b0;
        idle(3);
        bus.max7219_load = 1'b1;
        idle(4);
        bus.max7219_load = 1'b0;
        drain();
        check("t3_overrun", overrun_cnt, 1);
        check("t3_len_err", len_err_cnt, 1);
        check("t3_strobes", strobe_cnt, 13);

        // 4: reset mid-frame, then a clean frame
        clear_counts();
        for (int i = 0; i < 70; i++) shift_bit(1'(i % 3 == 0));
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(4);
        shift_frame(FRAME4);
        for (int k = 0; k < 8; k++) push(k, k + 1, 8'hA0 + k);
        pulse_load(1'b0);
        drain();
        check("t4_len_err", len_err_cnt, 0);
        check("t4_strobes", strobe_cnt, 8);

        // 6: 129 bits, words come from the last 128
        clear_counts();
        shift_bit(1'b1);
        shift_frame(FRAME1);
        push_frame1();
        pulse_load(1'b0);
        drain();
        check("t6_len_err", len_err_cnt, 1);
        check("t6_strobes", strobe_cnt, 8);

`ifdef MAX7219_RX_REGFILE_EN
        // 5: digit mirror
        clear_counts();
        shift_frame({8{16'h035A}});
        for (int k = 0; k < 8; k++) push(k, 3, 8'h5A);
        pulse_load(1'b0);
        drain();
        rd_matrix = 3'd4;
        rd_digit  = 3'd2;
        idle(2);
        check("t5_rd_5a", int'(rd_data), 8'h5A);
        shift_frame({8{16'h0C01}});
        for (int k = 0; k < 8; k++) push(k, 4'hC, 8'h01);
        pulse_load(1'b0);
        drain();
        idle(2);
        check("t5_rd_after_shutdown", int'(rd_data), 8'h5A);
`else
        rd_matrix = 3'd4;
        rd_digit  = 3'd2;
        idle(2);
        check("t5_rd_tied_zero", int'(rd_data), 0);
`endif

        check("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
